// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- register write-pending scoreboard for an in-order pipeline.
//
// Each architectural register 1..31 has a small countdown of the cycles left
// until its pending result reaches the forwarding network. While a source
// register of the instruction in ID is still counting, ID is stalled.
//
// Parameters
//   READ_PORTS : number of source-register read ports checked per cycle
//   LAT_W      : width of each per-register latency counter
//
// Ports
//   clk              in   sole clock, rising edge
//   rst              in   asynchronous active-high reset
//   hold_i           in   downstream freeze; counters hold their value
//   flush_i          in   discard every pending write
//   issue_valid_i    in   instruction in ID requests issue
//   issue_waddr_i    in   destination register of the issuing instruction
//   issue_lat_i      in   cycles until its result is forwardable (0 = untracked)
//   raddr_i          in   source registers of the instruction in ID
//   stall_o          out  ID must hold
//   issue_fire_o     out  issue accepted this cycle
//   busy_o           out  per-register pending-write flags (bit 0 always 0)
//   perf_stall_cnt_o out  count of stalled issue attempts
//
// Build option
//   REG_SCOREBOARD_STATS_EN : when defined, perf_stall_cnt_o is a wrapping
//   32-bit counter of edges with stall_o and issue_valid_i both high;
//   otherwise it is tied to 0 and no counter is built.

module reg_scoreboard #(
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned LAT_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold_i,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  input  logic [4:0]                 issue_waddr_i,
  input  logic [LAT_W-1:0]           issue_lat_i,
  input  logic [READ_PORTS-1:0][4:0] raddr_i,
  output logic                       stall_o,
  output logic                       issue_fire_o,
  output logic [31:0]                busy_o,
  output logic [31:0]                perf_stall_cnt_o
);

  // Register 0 is hardwired, so it owns no counter.
  logic [LAT_W-1:0] r_cnt [1:31];

  logic [31:0] w_busy;
  logic        w_stall;
  logic        w_fire;
  logic        w_load;

  always_comb begin
    w_busy = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // Stall uses the pre-edge counters only: an instruction issuing this cycle
  // never bypasses into its own reader check.
  always_comb begin
    w_stall = 1'b0;
    for (int unsigned i = 0; i < READ_PORTS; i++) begin
      if ((raddr_i[i] != 5'd0) && w_busy[raddr_i[i]]) begin
        w_stall = 1'b1;
      end
    end
  end

  // rst gates fire so the reset state reads 0 even with issue_valid_i high.
  assign w_fire = issue_valid_i & ~w_stall & ~hold_i & ~flush_i & ~rst;

  // Issues to r0 or with zero latency leave the scoreboard untouched.
  assign w_load = w_fire && (issue_waddr_i != 5'd0) && (issue_lat_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < 32; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned r = 1; r < 32; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (!hold_i) begin
      for (int unsigned r = 1; r < 32; r++) begin
        // A new write replaces the old countdown outright (WAW: later wins).
        if (w_load && (issue_waddr_i == 5'(r))) begin
          r_cnt[r] <= issue_lat_i;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  assign stall_o      = w_stall;
  assign issue_fire_o = w_fire;
  assign busy_o       = w_busy;

`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_stall && issue_valid_i) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset state, dependent-read stall timing,
// hold extension, WAW override, r0 / zero-latency issues, flush, mid-countdown
// reset and the optional stall statistics counter.

module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            hold_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic [4:0]      issue_waddr_i;
  logic [3:0]      issue_lat_i;
  logic [1:0][4:0] raddr_i;
  logic            stall_o;
  logic            issue_fire_o;
  logic [31:0]     busy_o;
  logic [31:0]     perf_stall_cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  reg_scoreboard #(.READ_PORTS(2), .LAT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .hold_i           (hold_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_waddr_i    (issue_waddr_i),
    .issue_lat_i      (issue_lat_i),
    .raddr_i          (raddr_i),
    .stall_o          (stall_o),
    .issue_fire_o     (issue_fire_o),
    .busy_o           (busy_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold_i        = 1'b0;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_waddr_i = 5'd0;
    issue_lat_i   = 4'd0;
    raddr_i       = '0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [3:0] l);
    issue_valid_i = 1'b1;
    issue_waddr_i = a;
    issue_lat_i   = l;
  endtask

  int unsigned stall_cycles;

  initial begin
    // ---- reset state (issue request present must not fire) ----
    idle();
    rst = 1'b1;
    issue(5'd5, 4'd3);
    raddr_i[0] = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fire",  {31'd0, issue_fire_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_busy",  busy_o, 32'd0);
    check("rst_perf",  perf_stall_cnt_o, 32'd0);
    idle();
    rst = 1'b0;
    tick();

    // ---- r5 lat 3, dependent reader stalls 3 cycles ----
    issue(5'd5, 4'd3);
    #1;
    check("t1_issue_fire", {31'd0, issue_fire_o}, 32'd1);
    tick();
    issue(5'd7, 4'd0);
    raddr_i[0] = 5'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t1_stall_c%0d", k), {31'd0, stall_o}, 32'd1);
      check($sformatf("t1_fire_c%0d", k), {31'd0, issue_fire_o}, 32'd0);
      tick();
    end
    check("t1_stall_c3", {31'd0, stall_o}, 32'd0);
    check("t1_fire_c3",  {31'd0, issue_fire_o}, 32'd1);
    check("t1_busy5_clr", {31'd0, busy_o[5]}, 32'd0);
    idle();
    tick();
    check("t1_perf", perf_stall_cnt_o, STATS ? 32'd3 : 32'd0);

    // ---- r8 lat 4, two hold cycles, reader on port 1 stalls 6 cycles ----
    issue(5'd8, 4'd4);
    tick();
    idle();
    raddr_i[1] = 5'd8;
    stall_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      hold_i = (c < 2);
      #1;
      if (stall_o) stall_cycles++;
      tick();
    end
    check("t2_stall_total", stall_cycles, 32'd6);
    check("t2_busy_end", busy_o, 32'd0);
    idle();

    // ---- WAW: r3 lat 5 then r3 lat 1 ----
    issue(5'd3, 4'd5);
    tick();
    check("t3_busy_after_first", busy_o, 32'h0000_0008);
    issue(5'd3, 4'd1);
    #1;
    check("t3_second_fire", {31'd0, issue_fire_o}, 32'd1);
    tick();
    idle();
    check("t3_busy_one_more", busy_o, 32'h0000_0008);
    tick();
    check("t3_busy_cleared", busy_o, 32'd0);

    // ---- r0 lat 7 and r9 lat 0 leave no trace ----
    issue(5'd0, 4'd7);
    tick();
    check("t4_r0_busy", busy_o, 32'd0);
    issue(5'd9, 4'd0);
    tick();
    check("t4_r9_busy", busy_o, 32'd0);
    idle();
    raddr_i[0] = 5'd0;
    raddr_i[1] = 5'd9;
    #1;
    check("t4_stall", {31'd0, stall_o}, 32'd0);
    idle();

    // ---- flush mid-countdown with an issue request present ----
    issue(5'd12, 4'd6);
    tick();
    idle();
    tick();
    tick();
    check("t5_busy_before_flush", busy_o, 32'h0000_1000);
    flush_i = 1'b1;
    issue(5'd13, 4'd3);
    #1;
    check("t5_flush_fire", {31'd0, issue_fire_o}, 32'd0);
    tick();
    idle();
    raddr_i[0] = 5'd12;
    raddr_i[1] = 5'd13;
    #1;
    check("t5_busy_after_flush", busy_o, 32'd0);
    check("t5_stall_after_flush", {31'd0, stall_o}, 32'd0);
    idle();

    // ---- asynchronous reset mid-countdown ----
    issue(5'd12, 4'd6);
    tick();
    idle();
    tick();
    check("t6_busy_before_rst", busy_o, 32'h0000_1000);
    rst = 1'b1;
    #1;
    check("t6_busy_in_rst", busy_o, 32'd0);
    check("t6_perf_in_rst", perf_stall_cnt_o, 32'd0);
    rst = 1'b0;
    tick();
    raddr_i[0] = 5'd12;
    #1;
    check("t6_busy_after_rst", busy_o, 32'd0);
    check("t6_stall_after_rst", {31'd0, stall_o}, 32'd0);
    idle();
    tick();

`ifdef REG_SCOREBOARD_STATS_EN
    // ---- statistics counter wraps from all-ones ----
    force dut.r_perf = 32'hFFFF_FFFE;
    #1;
    release dut.r_perf;
    issue(5'd5, 4'd2);
    tick();
    raddr_i[0] = 5'd5;
    tick();
    check("t7_perf_allones", perf_stall_cnt_o, 32'hFFFF_FFFF);
    tick();
    check("t7_perf_wrap", perf_stall_cnt_o, 32'd0);
    idle();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
